// File: rtl/chip8_mem_responder.sv
// Responder for chip8 processor byte requests: a 32-byte register file, a path to the
// main-memory BRAM, fixed-latency in-order read responses, timers and ROM-loader writes.
module chip8_mem_responder #(
   parameter int                 RAM_LATENCY = 2,
   parameter int                 TYPE_W      = 1,
   parameter logic [TYPE_W-1:0]  TYPE_REG    = '0,
   parameter logic [TYPE_W-1:0]  TYPE_RAM    = 1,
   parameter logic [15:0]        PC_RESET    = 16'h0200
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [11:0]       proc_addr_in,
   input  logic              proc_we_in,
   input  logic              proc_valid_in,
   input  logic [7:0]        proc_data_in,
   input  logic [TYPE_W-1:0] proc_type_in,
   output logic              proc_ready_out,
   output logic              proc_valid_out,
   output logic [7:0]        proc_data_out,
   input  logic              timer_decr_in,
   input  logic              load_busy_in,
   input  logic              load_valid_in,
   input  logic [11:0]       load_addr_in,
   input  logic [7:0]        load_data_in,
   output logic [11:0]       ram_addr_out,
   output logic              ram_we_out,
   output logic [7:0]        ram_din_out,
   input  logic [7:0]        ram_dout_in,
   output logic              active_audio_out,
   output logic [1:0]        error_out
);

   localparam int PIPE_D = RAM_LATENCY + 1;
   localparam int DT_IDX = 20;
   localparam int ST_IDX = 21;

   logic [7:0]        regs_q [32];
   logic [7:0]        regs_d [32];
   logic [PIPE_D-1:0] pv_q, pv_d;
   logic [PIPE_D-1:0] pram_q, pram_d;
   logic [7:0]        pdat_q [PIPE_D];
   logic [7:0]        pdat_d [PIPE_D];
   logic              proc_valid_q, proc_valid_d;
   logic [7:0]        proc_data_q, proc_data_d;
   logic [11:0]       ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [7:0]        ram_din_q, ram_din_d;
   logic              audio_q, audio_d;
   logic [1:0]        error_q, error_d;

   logic       accept;
   logic       is_reg;
   logic       is_ram;
   logic       reg_oor;
   logic [4:0] reg_idx;
   logic [7:0] reg_rdata;

   assign proc_ready_out = !rst_in && !load_busy_in;

   always_comb begin
      accept    = proc_valid_in && proc_ready_out;
      is_reg    = (proc_type_in == TYPE_REG);
      is_ram    = (proc_type_in == TYPE_RAM);
      reg_oor   = |proc_addr_in[11:5];
      reg_idx   = proc_addr_in[4:0];
      reg_rdata = reg_oor ? 8'h00 : regs_q[reg_idx];

      // Timers decrement first so a same-cycle processor write overrides the byte.
      regs_d = regs_q;
      if (timer_decr_in) begin
         if (regs_q[DT_IDX] != 8'h00) regs_d[DT_IDX] = regs_q[DT_IDX] - 8'd1;
         if (regs_q[ST_IDX] != 8'h00) regs_d[ST_IDX] = regs_q[ST_IDX] - 8'd1;
      end
      if (accept && is_reg && proc_we_in && !reg_oor) regs_d[reg_idx] = proc_data_in;

      pv_d      = {pv_q[PIPE_D-2:0], accept && !proc_we_in};
      pram_d    = {pram_q[PIPE_D-2:0], is_ram};
      pdat_d[0] = reg_rdata;
      for (int i = 1; i < PIPE_D; i++) pdat_d[i] = pdat_q[i-1];

      proc_valid_d = pv_q[PIPE_D-1];
      proc_data_d  = proc_data_q;
      if (pv_q[PIPE_D-1]) proc_data_d = pram_q[PIPE_D-1] ? ram_dout_in : pdat_q[PIPE_D-1];

      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      if (load_busy_in && load_valid_in) begin
         ram_we_d   = 1'b1;
         ram_addr_d = load_addr_in;
         ram_din_d  = load_data_in;
      end else if (accept && is_ram) begin
         ram_we_d   = proc_we_in;
         ram_addr_d = proc_addr_in;
         ram_din_d  = proc_data_in;
      end

      audio_d = (regs_q[ST_IDX] != 8'h00);
      error_d = error_q | {accept && is_reg && reg_oor, proc_valid_in && !proc_ready_out};
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
         regs_q[18] <= PC_RESET[15:8];
         regs_q[19] <= PC_RESET[7:0];
         pv_q       <= '0;
         pram_q     <= '0;
         for (int i = 0; i < PIPE_D; i++) pdat_q[i] <= 8'h00;
         proc_valid_q <= 1'b0;
         proc_data_q  <= 8'h00;
         ram_addr_q   <= 12'h000;
         ram_we_q     <= 1'b0;
         ram_din_q    <= 8'h00;
         audio_q      <= 1'b0;
         error_q      <= 2'b00;
      end else begin
         regs_q       <= regs_d;
         pv_q         <= pv_d;
         pram_q       <= pram_d;
         pdat_q       <= pdat_d;
         proc_valid_q <= proc_valid_d;
         proc_data_q  <= proc_data_d;
         ram_addr_q   <= ram_addr_d;
         ram_we_q     <= ram_we_d;
         ram_din_q    <= ram_din_d;
         audio_q      <= audio_d;
         error_q      <= error_d;
      end
   end

   assign proc_valid_out   = proc_valid_q;
   assign proc_data_out    = proc_data_q;
   assign ram_addr_out     = ram_addr_q;
   assign ram_we_out       = ram_we_q;
   assign ram_din_out      = ram_din_q;
   assign active_audio_out = audio_q;
   assign error_out        = error_q;

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Directed bench for chip8_mem_responder with a two-cycle BRAM model behind the RAM port.
module tb_chip8_mem_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [11:0] proc_addr_in;
   logic        proc_we_in;
   logic        proc_valid_in;
   logic [7:0]  proc_data_in;
   logic [0:0]  proc_type_in;
   logic        proc_ready_out;
   logic        proc_valid_out;
   logic [7:0]  proc_data_out;
   logic        timer_decr_in;
   logic        load_busy_in;
   logic        load_valid_in;
   logic [11:0] load_addr_in;
   logic [7:0]  load_data_in;
   logic [11:0] ram_addr_out;
   logic        ram_we_out;
   logic [7:0]  ram_din_out;
   logic [7:0]  ram_dout_in;
   logic        active_audio_out;
   logic [1:0]  error_out;

   int errors = 0;
   int checks = 0;

   chip8_mem_responder dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .proc_addr_in(proc_addr_in), .proc_we_in(proc_we_in), .proc_valid_in(proc_valid_in),
      .proc_data_in(proc_data_in), .proc_type_in(proc_type_in), .proc_ready_out(proc_ready_out),
      .proc_valid_out(proc_valid_out), .proc_data_out(proc_data_out),
      .timer_decr_in(timer_decr_in), .load_busy_in(load_busy_in), .load_valid_in(load_valid_in),
      .load_addr_in(load_addr_in), .load_data_in(load_data_in),
      .ram_addr_out(ram_addr_out), .ram_we_out(ram_we_out), .ram_din_out(ram_din_out),
      .ram_dout_in(ram_dout_in), .active_audio_out(active_audio_out), .error_out(error_out)
   );

   always #5 clk_in = ~clk_in;

   // BRAM model: data appears two clocks after the address
   logic [7:0] mem [4096];
   logic [7:0] rd1, rd2;
   always @(posedge clk_in) begin
      if (ram_we_out) mem[ram_addr_out] <= ram_din_out;
      rd1 <= mem[ram_addr_out];
      rd2 <= rd1;
   end
   assign ram_dout_in = rd2;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic write_reg(input logic [11:0] a, input logic [7:0] d);
      proc_addr_in = a; proc_data_in = d; proc_type_in = 1'b0; proc_we_in = 1'b1;
      proc_valid_in = 1'b1;
      tick();
      proc_valid_in = 1'b0; proc_we_in = 1'b0;
   endtask

   // Issues one read and reports the response latency (-1 if none within 8 cycles)
   task automatic do_read(input logic [11:0] a, input logic t, output logic [7:0] d, output int lat);
      proc_addr_in = a; proc_type_in = t; proc_we_in = 1'b0; proc_valid_in = 1'b1;
      tick();
      proc_valid_in = 1'b0;
      lat = -1; d = 8'h00;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (proc_valid_out && lat < 0) begin lat = i; d = proc_data_out; end
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      tick(); tick();
      checks++; if (proc_ready_out !== 1'b0) begin errors++; $display("FAIL ready_in_reset: got %b want 0", proc_ready_out); end
      rst_in = 1'b0;
      #1;
      checks++; if (proc_ready_out !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", proc_ready_out); end
      checks++; if (proc_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", proc_valid_out); end
      checks++; if (proc_data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", proc_data_out); end
      checks++; if (ram_we_out !== 1'b0 || ram_addr_out !== 12'h000 || ram_din_out !== 8'h00) begin
         errors++; $display("FAIL reset_ram: got we=%b addr=%h din=%h want 0/000/00", ram_we_out, ram_addr_out, ram_din_out); end
      checks++; if (error_out !== 2'b00) begin errors++; $display("FAIL reset_error: got %b want 00", error_out); end
      checks++; if (active_audio_out !== 1'b0) begin errors++; $display("FAIL reset_audio: got %b want 0", active_audio_out); end
   endtask

   task automatic test_back_to_back();
      proc_type_in = 1'b0; proc_we_in = 1'b0; proc_valid_in = 1'b1;
      proc_addr_in = 12'd18; tick();
      proc_addr_in = 12'd19; tick();
      proc_valid_in = 1'b0;
      tick();
      checks++; if (proc_valid_out !== 1'b0) begin errors++; $display("FAIL pc_early: got valid=%b at +2 want 0", proc_valid_out); end
      tick();
      checks++; if (proc_valid_out !== 1'b1 || proc_data_out !== 8'h02) begin
         errors++; $display("FAIL pc_hi: got valid=%b data=%h want 1/02", proc_valid_out, proc_data_out); end
      tick();
      checks++; if (proc_valid_out !== 1'b1 || proc_data_out !== 8'h00) begin
         errors++; $display("FAIL pc_lo: got valid=%b data=%h want 1/00", proc_valid_out, proc_data_out); end
      tick();
      checks++; if (proc_valid_out !== 1'b0) begin errors++; $display("FAIL pc_pulse_end: got %b want 0", proc_valid_out); end
   endtask

   task automatic test_reg_write_read();
      logic [7:0] d;
      int lat;
      int ram_we_seen = 0;
      write_reg(12'd5, 8'h3C);
      if (ram_we_out) ram_we_seen++;
      do_read(12'd5, 1'b0, d, lat);
      checks++; if (lat !== 3 || d !== 8'h3C) begin errors++; $display("FAIL reg5_read: got lat=%0d data=%h want 3/3c", lat, d); end
      checks++; if (ram_we_seen !== 0 || ram_addr_out !== 12'h000) begin
         errors++; $display("FAIL reg_no_ram: got we_seen=%0d addr=%h want 0/000", ram_we_seen, ram_addr_out); end
   endtask

   task automatic test_loader();
      int not_ready = 0;
      load_busy_in = 1'b1;
      #1;
      if (!proc_ready_out) not_ready++;
      load_valid_in = 1'b1; load_addr_in = 12'h200; load_data_in = 8'hA2;
      tick();
      if (!proc_ready_out) not_ready++;
      checks++; if (ram_we_out !== 1'b1 || ram_addr_out !== 12'h200 || ram_din_out !== 8'hA2) begin
         errors++; $display("FAIL load0: got we=%b addr=%h din=%h want 1/200/a2", ram_we_out, ram_addr_out, ram_din_out); end
      load_addr_in = 12'h201; load_data_in = 8'h2A;
      tick();
      if (!proc_ready_out) not_ready++;
      checks++; if (ram_we_out !== 1'b1 || ram_addr_out !== 12'h201 || ram_din_out !== 8'h2A) begin
         errors++; $display("FAIL load1: got we=%b addr=%h din=%h want 1/201/2a", ram_we_out, ram_addr_out, ram_din_out); end
      load_valid_in = 1'b0;
      tick();
      if (!proc_ready_out) not_ready++;
      checks++; if (ram_we_out !== 1'b0) begin errors++; $display("FAIL load_we_pulse: got %b want 0", ram_we_out); end
      checks++; if (not_ready !== 4) begin errors++; $display("FAIL ready_during_load: got %0d low cycles want 4", not_ready); end
      load_busy_in = 1'b0;
      proc_type_in = 1'b1; proc_we_in = 1'b0; proc_valid_in = 1'b1;
      proc_addr_in = 12'h200; tick();
      checks++; if (ram_addr_out !== 12'h200 || ram_we_out !== 1'b0) begin
         errors++; $display("FAIL ram_rd_addr: got addr=%h we=%b want 200/0", ram_addr_out, ram_we_out); end
      proc_addr_in = 12'h201; tick();
      proc_valid_in = 1'b0;
      tick(); tick();
      checks++; if (proc_valid_out !== 1'b1 || proc_data_out !== 8'hA2) begin
         errors++; $display("FAIL ram_rd0: got valid=%b data=%h want 1/a2", proc_valid_out, proc_data_out); end
      tick();
      checks++; if (proc_valid_out !== 1'b1 || proc_data_out !== 8'h2A) begin
         errors++; $display("FAIL ram_rd1: got valid=%b data=%h want 1/2a", proc_valid_out, proc_data_out); end
      tick();
   endtask

   task automatic test_timers();
      logic [7:0] d;
      int lat;
      write_reg(12'd21, 8'h02);
      tick();
      checks++; if (active_audio_out !== 1'b1) begin errors++; $display("FAIL audio_on: got %b want 1", active_audio_out); end
      timer_decr_in = 1'b1; tick(); timer_decr_in = 1'b0;
      do_read(12'd21, 1'b0, d, lat);
      checks++; if (lat !== 3 || d !== 8'h01) begin errors++; $display("FAIL st_dec1: got lat=%0d st=%h want 3/01", lat, d); end
      checks++; if (active_audio_out !== 1'b1) begin errors++; $display("FAIL audio_st1: got %b want 1", active_audio_out); end
      timer_decr_in = 1'b1; tick(); timer_decr_in = 1'b0;
      do_read(12'd21, 1'b0, d, lat);
      checks++; if (lat !== 3 || d !== 8'h00) begin errors++; $display("FAIL st_dec2: got lat=%0d st=%h want 3/00", lat, d); end
      timer_decr_in = 1'b1; tick(); timer_decr_in = 1'b0;
      do_read(12'd21, 1'b0, d, lat);
      checks++; if (lat !== 3 || d !== 8'h00) begin errors++; $display("FAIL st_sat: got lat=%0d st=%h want 3/00", lat, d); end
      checks++; if (active_audio_out !== 1'b0) begin errors++; $display("FAIL audio_off: got %b want 0", active_audio_out); end
      write_reg(12'd20, 8'h09);
      timer_decr_in = 1'b1;
      write_reg(12'd20, 8'h07);
      timer_decr_in = 1'b0;
      do_read(12'd20, 1'b0, d, lat);
      checks++; if (lat !== 3 || d !== 8'h07) begin errors++; $display("FAIL dt_write_wins: got lat=%0d dt=%h want 3/07", lat, d); end
   endtask

   task automatic test_errors();
      logic [7:0] d;
      int lat;
      int pulses = 0;
      write_reg(12'h045, 8'hFF);
      do_read(12'h040, 1'b0, d, lat);
      checks++; if (lat !== 3 || d !== 8'h00) begin errors++; $display("FAIL oor_read: got lat=%0d data=%h want 3/00", lat, d); end
      checks++; if (error_out !== 2'b10) begin errors++; $display("FAIL oor_err: got %b want 10", error_out); end
      do_read(12'd5, 1'b0, d, lat);
      checks++; if (d !== 8'h3C) begin errors++; $display("FAIL oor_write_ignored: got %h want 3c", d); end
      load_busy_in = 1'b1;
      proc_addr_in = 12'd18; proc_type_in = 1'b0; proc_we_in = 1'b0; proc_valid_in = 1'b1;
      tick();
      proc_valid_in = 1'b0; load_busy_in = 1'b0;
      checks++; if (error_out !== 2'b11) begin errors++; $display("FAIL busy_err: got %b want 11", error_out); end
      for (int i = 0; i < 6; i++) begin tick(); if (proc_valid_out) pulses++; end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL dropped_resp: got %0d pulses want 0", pulses); end
   endtask

   task automatic test_reset_inflight();
      logic [7:0] d;
      int lat;
      int pulses = 0;
      write_reg(12'd19, 8'h55);
      proc_addr_in = 12'h200; proc_type_in = 1'b1; proc_we_in = 1'b0; proc_valid_in = 1'b1;
      tick();
      proc_valid_in = 1'b0;
      rst_in = 1'b1;
      tick();
      if (proc_valid_out) pulses++;
      rst_in = 1'b0;
      for (int i = 0; i < 6; i++) begin tick(); if (proc_valid_out) pulses++; end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL flushed_resp: got %0d pulses want 0", pulses); end
      checks++; if (error_out !== 2'b00) begin errors++; $display("FAIL err_cleared: got %b want 00", error_out); end
      do_read(12'd19, 1'b0, d, lat);
      checks++; if (lat !== 3 || d !== 8'h00) begin errors++; $display("FAIL pcl_after_rst: got lat=%0d data=%h want 3/00", lat, d); end
      do_read(12'd18, 1'b0, d, lat);
      checks++; if (lat !== 3 || d !== 8'h02) begin errors++; $display("FAIL pch_after_rst: got lat=%0d data=%h want 3/02", lat, d); end
   endtask

   initial begin
      rst_in = 1'b1;
      proc_addr_in = 12'h000; proc_we_in = 1'b0; proc_valid_in = 1'b0;
      proc_data_in = 8'h00; proc_type_in = 1'b0;
      timer_decr_in = 1'b0; load_busy_in = 1'b0; load_valid_in = 1'b0;
      load_addr_in = 12'h000; load_data_in = 8'h00;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      test_reset();
      test_back_to_back();
      test_reg_write_read();
      test_loader();
      test_timers();
      test_errors();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
